// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector blocks: controller state
// encoding and the default pattern reused by other detector instances.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1101;

endpackage

// File: rtl/pattern_match_core.sv
// Serial overlapping pattern matcher: keeps the last PAT_W-1 bits and flags a
// hit combinationally when they plus the current bit equal PATTERN.
import seq_det_pkg::*;

module pattern_match_core #(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic hit
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;

    assign window = {hist, din};

    // fill saturates once enough history exists, so partial windows never hit
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= window[PAT_W-2:0];
            if (fill != FILL_FULL) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    assign hit = en && (fill == FILL_FULL) && (window == PATTERN);

endmodule

// File: rtl/seq_detect_ctrl.sv
// Byte-level controller: round-robin grant between two byte requesters, MSB-first
// serialisation through the pattern matcher, per-byte match count report.
import seq_det_pkg::*;

module seq_detect_ctrl #(
    parameter int               DATA_W  = 8,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               CNT_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        in_valid,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    output logic [1:0]        in_ready,
    output logic              busy,
    output logic              hit,
    output logic              done,
    output logic              done_id,
    output logic [CNT_W-1:0]  match_cnt
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  cnt;
    logic              cur_id;
    logic              last_grant;
    logic [1:0]        grant;
    logic              take;
    logic              grant_id;
    logic              shifting;
    logic              core_hit;

    // on a tie the requester that did not win last time is granted
    always_comb begin
        grant = 2'b00;
        if (!rst && state == IDLE) begin
            if (in_valid == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = in_valid;
            end
        end
    end

    assign in_ready = grant;
    assign take     = |(in_valid & grant);
    assign grant_id = grant[1];
    assign shifting = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = SHIFT;
            SHIFT:   if (bit_idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bit_idx    <= '0;
            cnt        <= '0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (take) begin
            shreg      <= grant_id ? in_data1 : in_data0;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            bit_idx    <= '0;
            cnt        <= '0;
        end else if (shifting) begin
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            bit_idx <= bit_idx + IDX_W'(1);
            if (core_hit) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // history is cleared on every accepted byte so patterns never span bytes
    pattern_match_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .clr (take),
        .en  (shifting),
        .din (shreg[DATA_W-1]),
        .hit (core_hit)
    );

    assign busy      = (state != IDLE);
    assign hit       = core_hit;
    assign done      = (state == DONE);
    assign done_id   = done & cur_id;
    assign match_cnt = done ? cnt : '0;

endmodule
